// File: rtl/mem_stage_lsu.sv
// Morty MEM stage: load/store unit on a Wishbone-style data bus, load formatting,
// alignment/bus fault detection, MEM->ID forwarding and the MEM/WB pipeline register.
module mem_stage_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mem_valid_i,
    input  logic [31:0]       mem_pc_i,
    input  logic [31:0]       mem_instruction_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic [XLEN-1:0]   mem_store_data_i,
    input  logic [4:0]        mem_waddr_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_op_i,
    input  logic [2:0]        mem_funct3_i,
    output logic              mem_stall_o,
    output logic [XLEN-1:0]   forward_mem_dat_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_dat_o,
    output logic [XLEN/8-1:0] dmem_sel_o,
    output logic              dmem_we_o,
    output logic              dmem_cyc_o,
    output logic              dmem_stb_o,
    input  logic [XLEN-1:0]   dmem_dat_i,
    input  logic              dmem_ack_i,
    input  logic              dmem_err_i,
    output logic [31:0]       wb_pc_o,
    output logic [31:0]       wb_instruction_o,
    output logic [XLEN-1:0]   wb_result_o,
    output logic [4:0]        wb_waddr_o,
    output logic              wb_we_o,
    output logic              wb_exc_o,
    output logic [3:0]        wb_exc_code_o,
    output logic [XLEN-1:0]   wb_badaddr_o
);

    localparam int unsigned SELW = XLEN / 8;
    localparam int unsigned OFFW = $clog2(SELW);
    localparam int unsigned CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit          IS64 = (XLEN == 64);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] WB_HOLD   = 2'd0;
    localparam logic [1:0] WB_BUBBLE = 2'd1;
    localparam logic [1:0] WB_PASS   = 2'd2;
    localparam logic [1:0] WB_ACC    = 2'd3;

    localparam logic [1:0]  OP_LOAD  = 2'b01;
    localparam logic [1:0]  OP_STORE = 2'b10;
    localparam logic [31:0] NOP      = 32'h0000_0033;

    logic            is_load, is_store, is_mem;
    logic            f3_legal, misaligned, mem_exc, access;
    logic [3:0]      exc_code;
    logic [OFFW-1:0] off;
    logic [SELW-1:0] sel_base;
    logic [XLEN-1:0] st_dat, aligned_addr;

    logic [1:0]      state_q, state_d, wb_act;
    logic            stall_c, start, resp, timeout;
    logic [CNTW-1:0] cnt_q;
    logic            killed_q;

    logic [31:0]     ctx_pc, ctx_instr;
    logic [4:0]      ctx_waddr;
    logic            ctx_we, ctx_load;
    logic [2:0]      ctx_f3;
    logic [XLEN-1:0] ctx_addr;
    logic            acc_fault;
    logic [XLEN-1:0] acc_result;

    // Select the addressed lane and sign/zero extend to XLEN.
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] raw,
                                                 input logic [2:0]      f3,
                                                 input logic [OFFW-1:0] lane);
        logic [XLEN-1:0] sh;
        sh = raw >> {lane, 3'b000};
        case (f3)
            3'b000:  fmt_load = XLEN'($signed(sh[7:0]));
            3'b001:  fmt_load = XLEN'($signed(sh[15:0]));
            3'b010:  fmt_load = XLEN'($signed(sh[31:0]));
            3'b100:  fmt_load = XLEN'(sh[7:0]);
            3'b101:  fmt_load = XLEN'(sh[15:0]);
            3'b110:  fmt_load = XLEN'(sh[31:0]);
            default: fmt_load = sh;
        endcase
    endfunction

    assign is_load      = (mem_op_i == OP_LOAD);
    assign is_store     = (mem_op_i == OP_STORE);
    assign is_mem       = is_load | is_store;
    assign off          = mem_result_i[OFFW-1:0];
    assign aligned_addr = {mem_result_i[XLEN-1:OFFW], OFFW'(0)};

    // Size legality and natural alignment of the access.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        if (is_load) begin
            case (mem_funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                3'b011, 3'b110:                         f3_legal = IS64;
                default:                                f3_legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (mem_funct3_i)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                3'b011:                 f3_legal = IS64;
                default:                f3_legal = 1'b0;
            endcase
        end
        case (mem_funct3_i[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_result_i[0];
            2'b10:   misaligned = |mem_result_i[1:0];
            default: misaligned = |mem_result_i[2:0];
        endcase
    end

    assign mem_exc  = mem_valid_i & is_mem & (~f3_legal | misaligned);
    assign access   = mem_valid_i & is_mem & f3_legal & ~misaligned & ~flush_i;
    assign exc_code = ~f3_legal ? (is_load ? 4'd5 : 4'd7) : (is_load ? 4'd4 : 4'd6);

    // Store byte enables and lane-replicated write data.
    always_comb begin
        sel_base = '1;
        st_dat   = mem_store_data_i;
        case (mem_funct3_i[1:0])
            2'b00: begin
                sel_base = SELW'(1);
                st_dat   = {SELW{mem_store_data_i[7:0]}};
            end
            2'b01: begin
                sel_base = SELW'(3);
                st_dat   = {(SELW/2){mem_store_data_i[15:0]}};
            end
            2'b10: begin
                sel_base = SELW'(15);
                st_dat   = {(SELW/4){mem_store_data_i[31:0]}};
            end
            default: begin
                sel_base = '1;
                st_dat   = mem_store_data_i;
            end
        endcase
    end

    assign timeout = (cnt_q == CNTW'(TIMEOUT - 1));
    assign resp    = dmem_ack_i | dmem_err_i | timeout;

    // Next state, stall request and WB register action.
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        start   = 1'b0;
        wb_act  = WB_HOLD;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
                    start   = 1'b1;
                    state_d = S_WAIT;
                    wb_act  = stall_i ? WB_HOLD : WB_BUBBLE;
                end else if (flush_i) begin
                    wb_act = WB_BUBBLE;
                end else if (!stall_i) begin
                    wb_act = mem_valid_i ? WB_PASS : WB_BUBBLE;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                wb_act  = (flush_i || !stall_i) ? WB_BUBBLE : WB_HOLD;
                if (resp) begin
                    state_d = (killed_q || flush_i) ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i) begin
                    wb_act  = WB_BUBBLE;
                    state_d = S_IDLE;
                end else if (!stall_i) begin
                    wb_act  = WB_ACC;
                    state_d = S_IDLE;
                end
            end
            default: begin
                wb_act  = WB_BUBBLE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Bus master registers, wait counter and captured access context.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmem_cyc_o  <= 1'b0;
            dmem_stb_o  <= 1'b0;
            dmem_we_o   <= 1'b0;
            dmem_addr_o <= '0;
            dmem_dat_o  <= '0;
            dmem_sel_o  <= '0;
            cnt_q       <= '0;
            killed_q    <= 1'b0;
            ctx_pc      <= '0;
            ctx_instr   <= '0;
            ctx_waddr   <= '0;
            ctx_we      <= 1'b0;
            ctx_load    <= 1'b0;
            ctx_f3      <= '0;
            ctx_addr    <= '0;
            acc_fault   <= 1'b0;
            acc_result  <= '0;
        end else if (start) begin
            dmem_cyc_o  <= 1'b1;
            dmem_stb_o  <= 1'b1;
            dmem_we_o   <= is_store;
            dmem_addr_o <= aligned_addr;
            dmem_dat_o  <= st_dat;
            dmem_sel_o  <= sel_base << off;
            cnt_q       <= '0;
            killed_q    <= 1'b0;
            ctx_pc      <= mem_pc_i;
            ctx_instr   <= mem_instruction_i;
            ctx_waddr   <= mem_waddr_i;
            ctx_we      <= mem_we_i;
            ctx_load    <= is_load;
            ctx_f3      <= mem_funct3_i;
            ctx_addr    <= mem_result_i;
        end else if (state_q == S_WAIT) begin
            if (flush_i) killed_q <= 1'b1;
            if (resp) begin
                dmem_cyc_o <= 1'b0;
                dmem_stb_o <= 1'b0;
                dmem_we_o  <= 1'b0;
                // err beats ack; silence means the timeout fired
                acc_fault  <= dmem_err_i | ~dmem_ack_i;
                acc_result <= (ctx_load & dmem_ack_i & ~dmem_err_i)
                              ? fmt_load(dmem_dat_i, ctx_f3, ctx_addr[OFFW-1:0])
                              : ctx_addr;
            end else begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i || wb_act == WB_BUBBLE) begin
            wb_pc_o          <= '0;
            wb_instruction_o <= NOP;
            wb_result_o      <= '0;
            wb_waddr_o       <= '0;
            wb_we_o          <= 1'b0;
            wb_exc_o         <= 1'b0;
            wb_exc_code_o    <= '0;
            wb_badaddr_o     <= '0;
        end else if (wb_act == WB_PASS) begin
            wb_pc_o          <= mem_pc_i;
            wb_instruction_o <= mem_instruction_i;
            wb_result_o      <= mem_result_i;
            wb_waddr_o       <= mem_waddr_i;
            wb_we_o          <= mem_we_i & ~mem_exc;
            wb_exc_o         <= mem_exc;
            wb_exc_code_o    <= mem_exc ? exc_code : 4'd0;
            wb_badaddr_o     <= mem_exc ? mem_result_i : '0;
        end else if (wb_act == WB_ACC) begin
            wb_pc_o          <= ctx_pc;
            wb_instruction_o <= ctx_instr;
            wb_result_o      <= acc_result;
            wb_waddr_o       <= ctx_waddr;
            wb_we_o          <= ctx_we & ctx_load & ~acc_fault;
            wb_exc_o         <= acc_fault;
            wb_exc_code_o    <= acc_fault ? (ctx_load ? 4'd5 : 4'd7) : 4'd0;
            wb_badaddr_o     <= acc_fault ? ctx_addr : '0;
        end
    end

    assign mem_stall_o       = stall_c;
    assign forward_mem_dat_o = (state_q == S_DONE) ? acc_result : mem_result_i;

endmodule
